// File: rtl/proc_pkg.sv
// Shared constants and types for the fetch front end.
package proc_pkg;

  localparam int              WIDTH    = 32;
  localparam int              PC_STEP  = 4;
  localparam logic [WIDTH-1:0] RESET_PC = 32'h0000_0000;

  // IDLE : out of reset, no request yet
  // FETCH: request outstanding at PC
  // HOLD : fetched word parked in the skid buffer while downstream stalls
  // DRAIN: waiting out a request abandoned by a redirect
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter with redirect load and sequential increment.
module pc_reg #(
  parameter int               WIDTH    = proc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(proc_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_seq
);
  import proc_pkg::*;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

  // Sequential successor; wraps modulo 2^WIDTH with no carry out.
  assign pc_seq = pc + STEP;

  // Load has priority over increment so a redirect always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block evaluation order.
      pc <= load_val;
    end else if (inc) begin
      pc <= pc_seq;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, memory handshake, skid buffer and the
// registered outputs feeding the pipeline buffer.
module fetch_stage #(
  parameter int               WIDTH    = proc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(proc_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_data,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_pc4,
  output logic             out_valid
);
  import proc_pkg::*;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc, pc_seq;
  logic [WIDTH-1:0] drain_addr;
  logic [WIDTH-1:0] skid_instr, skid_pc4;
  logic             pc_inc;
  logic [WIDTH-1:0] br_aligned;

  assign br_aligned = br_target & ~WIDTH'(3);
  assign pc_inc     = (state == FETCH) && imem_ack && !br_taken;

  pc_reg #(
    .WIDTH   (WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (br_taken),
    .inc     (pc_inc),
    .load_val(br_aligned),
    .pc      (pc),
    .pc_seq  (pc_seq)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode; a redirect outranks ack and stall.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (br_taken)            state_next = imem_ack ? FETCH : DRAIN;
        else if (imem_ack && stall) state_next = HOLD;
        else                     state_next = FETCH;
      end
      HOLD:  if (br_taken || !stall) state_next = FETCH;
      // A redirect during DRAIN only retargets PC; the abandoned request
      // still completes on ack, after which fetching resumes at PC.
      DRAIN: if (imem_ack) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // Moore memory-interface outputs.
  always_comb begin
    imem_req  = (state == FETCH) || (state == DRAIN);
    imem_addr = (state == DRAIN) ? drain_addr : pc;
  end

  // Remember the abandoned address so the request stays stable until ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      drain_addr <= '0;
    else if (state == FETCH && br_taken && !imem_ack) drain_addr <= pc;
  end

  // Skid buffer: catches a word that returns while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (br_taken) begin
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (state == FETCH && imem_ack && stall) begin
      skid_instr <= imem_data;
      skid_pc4   <= pc_seq;
    end
  end

  // Output registers toward the pipeline buffer; all hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_instr <= '0;
      out_pc4   <= '0;
      out_valid <= 1'b0;
    end else if (br_taken) begin
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH: if (!stall) begin
          if (imem_ack) begin
            out_instr <= imem_data;
            out_pc4   <= pc_seq;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end
        HOLD: if (!stall) begin
          out_instr <= skid_instr;
          out_pc4   <= skid_pc4;
          out_valid <= 1'b1;
        end
        DRAIN:   out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus reset/wrap sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_taken, imem_ack;
  logic [31:0] br_target, imem_data;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_instr, out_pc4;

  // Second instance with a reset PC just below the wrap point.
  logic        rst2_n, ack2;
  logic [31:0] data2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc42;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .out_instr(out_instr),
    .out_pc4(out_pc4), .out_valid(out_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(zero1), .br_taken(zero1),
    .br_target(zero32), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_data(data2), .out_instr(instr2),
    .out_pc4(pc42), .out_valid(valid2)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else             passed++;
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] d);
    stall = s; br_taken = b; br_target = t; imem_ack = a; imem_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               stall br tgt          ack data          req addr          instr         pc4           valid
    // zero-wait fetch from reset
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h0,   32'h0,   32'h0,   1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0,    1'b1, 32'h4,   32'h0,   32'h4,   1'b1};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h4,    1'b1, 32'h8,   32'h4,   32'h8,   1'b1};
    // stall three cycles while word 8 returns; skid then replay
    tbl[3]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,    1'b0, 32'hC,   32'h4,   32'h8,   1'b1};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'hC,   32'h4,   32'h8,   1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,    1'b0, 32'hC,   32'h4,   32'h8,   1'b1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'hC,   32'h8,   32'hC,   1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,    1'b1, 32'h10,  32'hC,   32'h10,  1'b1};
    // slow memory: request 0x10 pending, redirect to 0x100, drain
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h10,  32'hC,   32'h10,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,    1'b1, 32'h10,  32'hC,   32'h10,  1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,    1'b1, 32'h10,  32'hC,   32'h10,  1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hDEAD, 1'b1, 32'h100, 32'hC,   32'h10,  1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100,  1'b1, 32'h104, 32'h100, 32'h104, 1'b1};
    // redirect + stall + ack together, unaligned target
    tbl[13] = '{1'b1, 1'b1, 32'h203, 1'b1, 32'h104,  1'b1, 32'h200, 32'h100, 32'h104, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h200,  1'b1, 32'h204, 32'h200, 32'h204, 1'b1};
    // redirect out of HOLD discards the skid word
    tbl[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204,  1'b0, 32'h208, 32'h200, 32'h204, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 32'h300, 1'b0, 32'h0,    1'b1, 32'h300, 32'h200, 32'h204, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h300,  1'b1, 32'h304, 32'h300, 32'h304, 1'b1};

    rst_n = 1'b0; rst2_n = 1'b0; ack2 = 1'b0; data2 = '0;
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    tick();

    check("rst.req",   32'(imem_req),  32'h0);
    check("rst.addr",  imem_addr,      32'h0);
    check("rst.instr", out_instr,      32'h0);
    check("rst.pc4",   out_pc4,        32'h0);
    check("rst.valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].ack, tbl[i].data);
      tick();
      check($sformatf("v%0d.req", i),   32'(imem_req),  32'(tbl[i].e_req));
      check($sformatf("v%0d.addr", i),  imem_addr,      tbl[i].e_addr);
      check($sformatf("v%0d.instr", i), out_instr,      tbl[i].e_instr);
      check($sformatf("v%0d.pc4", i),   out_pc4,        tbl[i].e_pc4);
      check($sformatf("v%0d.valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
    end

    // Reset in the middle of DRAIN: outputs clear without waiting for a clock.
    drive(1'b0, 1'b1, 32'h400, 1'b0, '0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0);
    check("drain.entry_addr", imem_addr, 32'h304);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.req",   32'(imem_req),  32'h0);
    check("rstmid.addr",  imem_addr,      32'h0);
    check("rstmid.instr", out_instr,      32'h0);
    check("rstmid.pc4",   out_pc4,        32'h0);
    check("rstmid.valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("restart.req",  32'(imem_req), 32'h1);
    check("restart.addr", imem_addr,     32'h0);
    drive(1'b0, 1'b0, '0, 1'b1, 32'h0);
    tick();
    check("restart.instr", out_instr,      32'h0);
    check("restart.pc4",   out_pc4,        32'h4);
    check("restart.valid", 32'(out_valid), 32'h1);
    check("restart.next",  imem_addr,      32'h4);

    // PC wrap from 0xFFFF_FFFC.
    rst2_n = 1'b1;
    tick();
    check("wrap.addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; data2 = 32'hAAAA_5555;
    tick();
    check("wrap.instr", instr2,      32'hAAAA_5555);
    check("wrap.pc4",   pc42,        32'h0);
    check("wrap.valid", 32'(valid2), 32'h1);
    check("wrap.addr1", addr2,       32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
